// File: rtl/clkctrl_seq.sv
// Clock-mode sequencer: region-decodes the CPU address and drives the hs/ls clock switch and dividers.
// Latency: decode to hsclk_sel is 1 cycle; switch ack is seen 2 cycles after it toggles (2-flop synchroniser).
module clkctrl_seq #(
    parameter int ADDR_W  = 16,
    parameter int PAGE_W  = 4,
    parameter int NREGION = 4,
    parameter int DIV_W   = 2,
    parameter int HOLD_W  = 4,
    parameter int TO_W    = 6,
    localparam int IDX_W  = (NREGION > 1) ? $clog2(NREGION) : 1,
    localparam int ENT_W  = 2*PAGE_W + 2 + DIV_W
) (
    input  logic                clkout,
    input  logic                rst_resync1_qb,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_vda,
    input  logic                force_slow,
    input  logic [HOLD_W-1:0]   hold_cycles,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [ENT_W-1:0]    cfg_wdata,
    input  logic                hsclk_selected,
    output logic                hsclk_sel,
    output logic [DIV_W-1:0]    cpuclk_div_sel,
    output logic [DIV_W-1:0]    hsclk_div_sel,
    output logic                busy,
    output logic [NREGION-1:0]  region_hit,
    output logic                ack_timeout
);
    localparam logic [1:0] SLOW    = 2'd0;
    localparam logic [1:0] TO_FAST = 2'd1;
    localparam logic [1:0] FAST    = 2'd2;
    localparam logic [1:0] TO_SLOW = 2'd3;

    logic                en_q   [NREGION];
    logic                fast_q [NREGION];
    logic [DIV_W-1:0]    div_q  [NREGION];
    logic [PAGE_W-1:0]   base_q [NREGION];
    logic [PAGE_W-1:0]   mask_q [NREGION];

    logic [1:0]          state_q, state_d;
    logic                sel_q, sel_d;
    logic [DIV_W-1:0]    cdiv_q, cdiv_d, hdiv_q, hdiv_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                tout_q, tout_d;
    logic [NREGION-1:0]  hit_q, hit_d;
    logic                ack_s1_q, ack_s2_q;

    logic [PAGE_W-1:0]   page;
    logic                found, win_fast, slow_req;
    logic [DIV_W-1:0]    win_div;
    logic                unused_addr_lo;

    assign page           = cpu_addr[ADDR_W-1 -: PAGE_W];
    assign unused_addr_lo = ^cpu_addr[ADDR_W-PAGE_W-1:0];

    // Lowest matching index wins; table writes this cycle are not yet visible.
    always_comb begin
        hit_d    = '0;
        found    = 1'b0;
        win_fast = 1'b0;
        win_div  = '0;
        for (int i = 0; i < NREGION; i++) begin
            if (!found && en_q[i] && ((page & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
                found    = 1'b1;
                hit_d[i] = 1'b1;
                win_fast = fast_q[i];
                win_div  = div_q[i];
            end
        end
    end

    assign slow_req = force_slow | (cpu_vda & (~found | ~win_fast));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cdiv_d  = cdiv_q;
        hdiv_d  = hdiv_q;
        hold_d  = hold_q;
        to_d    = to_q;
        case (state_q)
            FAST: begin
                if (slow_req) begin
                    sel_d   = 1'b0;
                    state_d = TO_SLOW;
                    to_d    = '0;
                end else if (cpu_vda && found && win_fast) begin
                    cdiv_d = win_div;
                    hdiv_d = win_div;
                end
            end
            TO_SLOW: begin
                if (to_q != '1) to_d = to_q + 1'b1;
                if (!ack_s2_q) begin
                    state_d = SLOW;
                    hold_d  = hold_cycles;
                end
            end
            SLOW: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!slow_req) begin
                    sel_d   = 1'b1;
                    state_d = TO_FAST;
                    to_d    = '0;
                end
            end
            default: begin
                if (to_q != '1) to_d = to_q + 1'b1;
                if (ack_s2_q) state_d = FAST;
            end
        endcase
        // Sticky: the FSM keeps waiting, software sees the flag.
        tout_d = tout_q | ((state_q == TO_SLOW || state_q == TO_FAST) && to_d == '1);
    end

    always_ff @(posedge clkout or negedge rst_resync1_qb) begin
        if (!rst_resync1_qb) begin
            state_q  <= SLOW;
            sel_q    <= 1'b0;
            cdiv_q   <= '0;
            hdiv_q   <= '0;
            hold_q   <= '0;
            to_q     <= '0;
            tout_q   <= 1'b0;
            hit_q    <= '0;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            for (int i = 0; i < NREGION; i++) begin
                en_q[i]   <= 1'b0;
                fast_q[i] <= 1'b0;
                div_q[i]  <= '0;
                base_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cdiv_q   <= cdiv_d;
            hdiv_q   <= hdiv_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            tout_q   <= tout_d;
            hit_q    <= hit_d;
            ack_s1_q <= hsclk_selected;
            ack_s2_q <= ack_s1_q;
            for (int i = 0; i < NREGION; i++) begin
                if (cfg_we && cfg_idx == IDX_W'(i)) begin
                    en_q[i]   <= cfg_wdata[ENT_W-1];
                    fast_q[i] <= cfg_wdata[ENT_W-2];
                    div_q[i]  <= cfg_wdata[2*PAGE_W +: DIV_W];
                    base_q[i] <= cfg_wdata[PAGE_W +: PAGE_W];
                    mask_q[i] <= cfg_wdata[0 +: PAGE_W];
                end
            end
        end
    end

    assign hsclk_sel      = sel_q;
    assign cpuclk_div_sel = cdiv_q;
    assign hsclk_div_sel  = hdiv_q;
    assign busy           = (state_q == TO_SLOW) || (state_q == TO_FAST);
    assign region_hit     = hit_q;
    assign ack_timeout    = tout_q;

endmodule

// File: tb/tb_clkctrl_seq.sv
// Directed bench for clkctrl_seq; FSM state is observed through {hsclk_sel, busy}.
module tb_clkctrl_seq;
    logic        clkout = 1'b0;
    logic        rst_resync1_qb;
    logic [15:0] cpu_addr;
    logic        cpu_vda;
    logic        force_slow;
    logic [3:0]  hold_cycles;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [11:0] cfg_wdata;
    logic        hsclk_selected;
    logic        hsclk_sel;
    logic [1:0]  cpuclk_div_sel;
    logic [1:0]  hsclk_div_sel;
    logic        busy;
    logic [3:0]  region_hit;
    logic        ack_timeout;

    int vectors    = 0;
    int miscompares = 0;

    clkctrl_seq dut (
        .clkout         (clkout),
        .rst_resync1_qb (rst_resync1_qb),
        .cpu_addr       (cpu_addr),
        .cpu_vda        (cpu_vda),
        .force_slow     (force_slow),
        .hold_cycles    (hold_cycles),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_wdata      (cfg_wdata),
        .hsclk_selected (hsclk_selected),
        .hsclk_sel      (hsclk_sel),
        .cpuclk_div_sel (cpuclk_div_sel),
        .hsclk_div_sel  (hsclk_div_sel),
        .busy           (busy),
        .region_hit     (region_hit),
        .ack_timeout    (ack_timeout)
    );

    always #5 clkout = ~clkout;

    task automatic tick();
        @(posedge clkout);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hsclk_sel, busy}: SLOW=00, TO_FAST=11, FAST=10, TO_SLOW=01
    task automatic chk_st(input string tag, input logic [1:0] exp);
        chk(tag, 32'({hsclk_sel, busy}), 32'(exp));
    endtask

    initial begin
        rst_resync1_qb = 1'b0;
        cpu_addr       = 16'h8000;
        cpu_vda        = 1'b1;
        force_slow     = 1'b0;
        hold_cycles    = 4'd0;
        cfg_we         = 1'b0;
        cfg_idx        = 2'd0;
        cfg_wdata      = 12'h000;
        hsclk_selected = 1'b0;
        tick();
        tick();
        chk_st("rst_state", 2'b00);
        chk("rst_div", 32'({cpuclk_div_sel, hsclk_div_sel}), 32'h0);
        chk("rst_hit", 32'(region_hit), 32'h0);
        chk("rst_tout", 32'(ack_timeout), 32'h0);
        rst_resync1_qb = 1'b1;

        // Empty table: address does not match, stays SLOW.
        tick(); tick(); tick();
        chk_st("empty_slow", 2'b00);
        chk("empty_hit", 32'(region_hit), 32'h0);

        // idx0 = {en1 fast1 div01 base8 maskC}; decode on the write edge still sees the old table.
        cpu_addr = 16'h9000; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wdata = 12'hD8C;
        tick();
        cfg_we = 1'b0;
        chk_st("wr_edge_slow", 2'b00);
        chk("wr_edge_hit", 32'(region_hit), 32'h0);
        tick();
        chk_st("req_fast", 2'b11);
        chk("req_hit", 32'(region_hit), 32'h1);
        hsclk_selected = 1'b1;
        tick();
        chk_st("sync1_wait", 2'b11);
        tick();
        chk_st("sync2_wait", 2'b11);
        tick();
        chk_st("fast_entry", 2'b10);
        chk("div_frozen", 32'(cpuclk_div_sel), 32'h0);
        tick();
        chk("cdiv_fast", 32'(cpuclk_div_sel), 32'h1);
        chk("hdiv_fast", 32'(hsclk_div_sel), 32'h1);
        chk("fast_hit", 32'(region_hit), 32'h1);

        // No-match address forces the drop to SLOW, then a 5-cycle dwell.
        cpu_addr = 16'hFE00;
        tick();
        chk_st("nomatch_toslow", 2'b01);
        chk("nomatch_hit", 32'(region_hit), 32'h0);
        hsclk_selected = 1'b0; hold_cycles = 4'd5;
        tick(); tick();
        chk_st("toslow_wait", 2'b01);
        tick();
        chk_st("slow_entry", 2'b00);
        chk("div_frozen_slow", 32'(cpuclk_div_sel), 32'h1);
        cpu_addr = 16'h9000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_st("dwell", 2'b00);
        end
        tick();
        chk_st("dwell_exit", 2'b11);

        // Ack held low in TO_FAST: counter reaches all-ones on the 63rd cycle after entry.
        for (int i = 0; i < 62; i++) tick();
        chk("tout_before", 32'(ack_timeout), 32'h0);
        tick();
        chk("tout_set", 32'(ack_timeout), 32'h1);
        tick(); tick(); tick();
        chk("tout_sticky", 32'(ack_timeout), 32'h1);
        chk_st("tout_still_waiting", 2'b11);
        hsclk_selected = 1'b1;
        tick(); tick(); tick();
        chk_st("tout_fast", 2'b10);
        chk("tout_after_fast", 32'(ack_timeout), 32'h1);

        // force_slow overrides a fast match; reset mid-transition clears everything.
        force_slow = 1'b1;
        tick();
        chk_st("force_toslow", 2'b01);
        tick();
        chk_st("force_hold", 2'b01);
        #2 rst_resync1_qb = 1'b0;
        #1;
        chk_st("arst_state", 2'b00);
        chk("arst_tout", 32'(ack_timeout), 32'h0);
        chk("arst_div", 32'({cpuclk_div_sel, hsclk_div_sel}), 32'h0);
        chk("arst_hit", 32'(region_hit), 32'h0);
        #2 rst_resync1_qb = 1'b1;
        force_slow = 1'b0; hsclk_selected = 1'b0; hold_cycles = 4'd0;
        tick();
        chk_st("cleared_slow", 2'b00);
        chk("cleared_hit", 32'(region_hit), 32'h0);

        // Priority: idx0 slow and idx1 fast both cover 0x8xxx.
        cpu_addr = 16'h8000;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wdata = 12'h88C;
        tick();
        cfg_idx = 2'd1; cfg_wdata = 12'hE88;
        tick();
        cfg_we = 1'b0;
        tick();
        chk_st("prio_slow", 2'b00);
        chk("prio_hit0", 32'(region_hit), 32'h1);
        tick();
        chk_st("prio_slow2", 2'b00);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wdata = 12'h000;
        tick();
        cfg_we = 1'b0;
        chk("prio_old_hit", 32'(region_hit), 32'h1);
        tick();
        chk("prio_hit1", 32'(region_hit), 32'h2);
        chk_st("prio_tofast", 2'b11);
        hsclk_selected = 1'b1;
        tick(); tick(); tick();
        chk_st("prio_fast", 2'b10);
        tick();
        chk("prio_cdiv", 32'(cpuclk_div_sel), 32'h2);
        chk("prio_hdiv", 32'(hsclk_div_sel), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/clkctrl_seq.md
Name: clkctrl_seq

Overview:
- Parametrised clock-mode sequencer in the CPU clock (clkout) domain; successor to the fixed two-speed clock controller.
- Decodes each CPU address against a programmable region table and decides whether the CPU runs from the high-speed or the low-speed clock, and at which divide ratio.
- Drives the clock switch's hsclk_sel and divider selects, and waits for the switch's hsclk_selected acknowledgement.
- Enforces a minimum low-speed dwell time so the CPU does not thrash between clocks.

Parameters:
- ADDR_W, 16, CPU address width
- PAGE_W, 4, number of top address bits compared by the region decode
- NREGION, 4, number of region table entries (min 1)
- DIV_W, 2, width of the hsclk and cpuclk divide-select fields
- HOLD_W, 4, width of the minimum low-speed dwell counter
- TO_W, 6, width of the switch-acknowledge timeout counter

Ports:
- clkout  in  1  CPU clock; all state updates on its rising edge
- rst_resync1_qb  in  1  asynchronous active-low reset
- cpu_addr  in  ADDR_W  current CPU address
- cpu_vda  in  1  cpu_addr valid this cycle
- force_slow  in  1  request low speed regardless of decode
- hold_cycles  in  HOLD_W  minimum number of clkout cycles to spend in SLOW
- cfg_we  in  1  region table write strobe
- cfg_idx  in  max(1,$clog2(NREGION))  entry index to write
- cfg_wdata  in  2*PAGE_W+2+DIV_W  entry fields, MSB first: {en, fast, div[DIV_W], base[PAGE_W], mask[PAGE_W]}
- hsclk_selected  in  1  switch acknowledge; asynchronous to clkout
- hsclk_sel  out  1  request high-speed clock
- cpuclk_div_sel  out  DIV_W  CPU divide select for the fast clock
- hsclk_div_sel  out  DIV_W  hsclk divide select; the div field of the last matching fast region
- busy  out  1  high in TO_SLOW and TO_FAST
- region_hit  out  NREGION  registered one-hot index of the winning entry; all zero if no entry matched
- ack_timeout  out  1  sticky switch-timeout error flag

Behaviour:
- Reset values:
  - state = SLOW, hsclk_sel = 0
  - cpuclk_div_sel = 0, hsclk_div_sel = 0
  - busy = 0, region_hit = 0, ack_timeout = 0
  - hold counter = 0, timeout counter = 0
  - every table entry en = 0
  - both synchroniser flops = 0
- hsclk_selected passes through a 2-flop synchroniser. ack_s is the second stage, giving 2-cycle latency.
- Region decode (combinational):
  - Entry i matches when en_i && ((cpu_addr[ADDR_W-1 -: PAGE_W] & mask_i) == (base_i & mask_i)).
  - The lowest matching index wins.
- slow_req = force_slow | (cpu_vda & (no match | winning fast == 0)). When cpu_vda = 0 with force_slow = 0, slow_req = 0.
- FSM transitions, one per rising edge:
  - FAST: if slow_req, clear hsclk_sel and go to TO_SLOW. Otherwise, if cpu_vda and the winner has fast = 1, register cpuclk_div_sel and hsclk_div_sel from the winner's div.
  - TO_SLOW: when ack_s == 0, go to SLOW and load the hold counter with hold_cycles.
  - SLOW: while the hold counter != 0, decrement it. When it is 0 and slow_req == 0, set hsclk_sel and go to TO_FAST. With hold_cycles = 0, exit is possible on the first SLOW cycle.
  - TO_FAST: when ack_s == 1, go to FAST.
- Divide selects change only in FAST; they are frozen in all other states.
- region_hit is registered every cycle from the decode, regardless of state.
- Timeout:
  - The timeout counter clears on entry to TO_SLOW or TO_FAST and increments each cycle spent there, saturating at all-ones.
  - On reaching all-ones, set ack_timeout (sticky until reset). The FSM keeps waiting; there is no forced exit.
- Table writes:
  - On cfg_we, entry cfg_idx takes cfg_wdata on that edge.
  - The decode in the same cycle uses the old contents.
  - cfg_idx >= NREGION is ignored.
- Reset asserted mid-transition returns immediately to the reset values; the table is cleared.

Test Plan:
- Reset, table empty, cpu_vda = 1, addr 0x8000 -> state stays SLOW, hsclk_sel = 0, region_hit = 0.
- Write idx 0 = {en=1, fast=1, div=2'b01, base=4'h8, mask=4'hC}, hold_cycles = 0, addr 0x9000 -> hsclk_sel rises the next cycle. Drive hsclk_selected = 1: FAST is entered 3 cycles after the request (2 sync + 1), and the first FAST cycle latches cpuclk_div_sel = 1. region_hit = 4'b0001 throughout.
- In FAST, addr 0xFE00 (no match) -> hsclk_sel = 0 next cycle, busy = 1. Drop hsclk_selected -> SLOW 3 cycles later. With hold_cycles = 5 and addr back to 0x9000, hsclk_sel re-asserts only after 5 SLOW cycles.
- Entries 0 and 1 both match 0x8xxx (idx 0 fast=0, idx 1 fast=1) -> idx 0 wins, slow_req = 1, region_hit = 4'b0001.
- In TO_FAST, hold hsclk_selected = 0 for 64 cycles -> ack_timeout = 1 and stays 1. Then raise the ack -> FAST; ack_timeout is still 1.
- Assert force_slow in FAST with a fast address -> TO_SLOW. Pulse reset in TO_SLOW -> SLOW, table cleared, ack_timeout = 0.
